dcache_wb_ctrl: RTL and testbench
=================================

Name: dcache_wb_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache for the pipelined CPU.
- Sits between the CPU's MEM stage and the off-chip data memory.
- Holds the MEM stage through p1_stall_o on a miss; the CPU feeds that stall into its global hazard/stall path.
- Line transfers use a single-beat enable/ack handshake to a slow 256-bit memory.

Parameters:
INDEX_W, 5, index width; number of lines = 2**INDEX_W (default 32)
LINE_W, 256, line width in bits (32 bytes, 8 words); fixed, not overridable in this revision

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-low
p1_req_i  in  1  CPU access valid this cycle (load or store)
p1_write_i  in  1  1 = store, 0 = load
p1_addr_i  in  32  byte address, word aligned
p1_data_i  in  32  store data
p1_data_o  out  32  load data, valid when p1_req_i & ~p1_write_i & ~p1_stall_o
p1_stall_o  out  1  hold MEM stage
mem_enable_o  out  1  memory request
mem_write_o  out  1  1 = line write-back, 0 = line read
mem_addr_o  out  32  line address, bits [4:0] = 0
mem_data_o  out  256  write-back line
mem_data_i  in  256  refill line
mem_ack_i  in  1  one-cycle completion pulse
hit_cnt_o  out  32  completed hits
miss_cnt_o  out  32  misses
wb_cnt_o  out  32  dirty write-backs

Behaviour:
- Address split: tag = [31:INDEX_W+5], index = [INDEX_W+4:5], word = [4:2]. Per line: valid, dirty, tag, 256-bit data.
- Reset (rst_i low, async, any state):
  - state = IDLE; all valid and dirty bits = 0; counters = 0.
  - p1_stall_o = 0, mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0, p1_data_o = 0.
  - An in-flight memory transaction is abandoned; a later mem_ack_i is ignored unless the FSM is in a wait state.
- Hit = p1_req_i & valid[index] & (tag match).
- IDLE:
  - No request: stall 0.
  - Load hit: p1_data_o = addressed word combinationally, same cycle, stall 0; hit_cnt +1 at the clock edge.
  - Store hit: word written at the clock edge, dirty set, stall 0; hit_cnt +1.
  - Miss: p1_stall_o = 1 combinationally in the same cycle; miss_cnt +1.
    - Go to WB if the victim is valid and dirty, else go to RF.
- WB:
  - mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim line.
  - Stall 1. On mem_ack_i: wb_cnt +1, go to RF.
- RF:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {req tag, index, 5'b0}. Stall 1.
  - On mem_ack_i: install mem_data_i, valid = 1, dirty = 0, tag = req tag, go to FILL.
- FILL:
  - One cycle. Stall 1, mem_enable_o = 0.
  - Go to IDLE, where the held request re-evaluates as a hit. That hit completes the access and increments hit_cnt; a miss therefore counts both a miss and a hit.
- Memory handshake:
  - mem_enable_o and the address/data outputs stay constant from state entry until mem_ack_i is sampled.
  - mem_enable_o drops in the cycle after ack, and is low for at least one cycle between any two transactions.
- Request held constant by the CPU while stall = 1. A changed request during a miss is undefined.
- p1_data_o when no load hit: 0.
- Counters wrap at 2**32.
- Stores never write through; memory is updated only by write-back.

Test Plan:
- Reset mid-WB (rst_i low 1 cycle while mem_enable_o = 1) -> all outputs 0 within the same cycle, state IDLE, a re-issued load of 0x40 misses with no write-back (valid cleared).
- Cold load 0x00, memory acks 10 cycles after enable with line word0 = 5 -> mem read of 0x00, stall high 12 cycles, then p1_data_o = 5 with stall 0; miss_cnt = 1, hit_cnt = 1.
- Then load 0x04 (word1 = 8) -> same-cycle hit, p1_data_o = 8, stall never asserts; hit_cnt = 2.
- Store 0x08 = 0xDEADBEEF (hit), then load 0x400 (same index 0, different tag) -> WB to 0x00 with mem_data_o[95:64] = 0xDEADBEEF, then RF of 0x400; wb_cnt = 1, miss_cnt = 2.
- Load 0x420 (index 1, clean, invalid) then load 0x820 (index 1, clean conflict) -> two refills, no write-back, mem_write_o never 1, wb_cnt unchanged.
- Ack timing: mem_ack_i delayed to 1 cycle, then 50 cycles -> mem_enable_o, mem_addr_o and mem_data_o stable throughout each wait, enable low exactly the cycle after ack, correct data returned in both cases.

Source files
------------

// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped write-back, write-allocate data cache between the CPU MEM stage
// and a slow 256-bit line memory with a single-beat enable/ack handshake.
module dcache_wb_ctrl #(
    parameter int unsigned INDEX_W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         p1_req_i,
    input  logic         p1_write_i,
    input  logic [31:0]  p1_addr_i,
    input  logic [31:0]  p1_data_i,
    output logic [31:0]  p1_data_o,
    output logic         p1_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o,
    output logic [31:0]  wb_cnt_o
);
    localparam int unsigned LINE_W = 256;
    localparam int unsigned LINES  = 1 << INDEX_W;
    localparam int unsigned TAG_W  = 32 - INDEX_W - 5;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_RF, S_FILL} state_t;

    state_t                state_q;
    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [LINE_W-1:0]     data_q [LINES];

    logic                  mem_enable_q;
    logic                  mem_write_q;
    logic [31:0]           mem_addr_q;
    logic [LINE_W-1:0]     mem_data_q;
    logic [31:0]           hit_cnt_q;
    logic [31:0]           miss_cnt_q;
    logic [31:0]           wb_cnt_q;

    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_W-1:0]    req_idx;
    logic [2:0]            req_word;
    logic [LINE_W-1:0]     rd_line;
    logic [31:0]           rd_word;
    logic                  line_hit;
    logic                  idle_hit;
    logic                  idle_miss;
    logic                  victim_dirty;
    logic                  rf_done;
    logic                  unused_ok;

    assign req_tag      = p1_addr_i[31 -: TAG_W];
    assign req_idx      = p1_addr_i[INDEX_W+4:5];
    assign req_word     = p1_addr_i[4:2];
    assign unused_ok    = ^p1_addr_i[1:0];

    assign rd_line      = data_q[req_idx];
    assign rd_word      = rd_line[{req_word, 5'b0} +: 32];
    assign line_hit     = p1_req_i & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    assign idle_hit     = (state_q == S_IDLE) & line_hit;
    assign idle_miss    = (state_q == S_IDLE) & p1_req_i & ~line_hit;
    assign victim_dirty = valid_q[req_idx] & dirty_q[req_idx];
    assign rf_done      = (state_q == S_RF) & mem_enable_q & mem_ack_i;

    // Stall and load data answer in the same cycle; reset forces both low.
    assign p1_stall_o   = rst_i & ((state_q != S_IDLE) | idle_miss);
    assign p1_data_o    = (rst_i & idle_hit & ~p1_write_i) ? rd_word : 32'd0;

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign hit_cnt_o    = hit_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;
    assign wb_cnt_o     = wb_cnt_q;

    // Controller: miss sequencing, line state bits, memory port and counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_data_q   <= '0;
            hit_cnt_q    <= 32'd0;
            miss_cnt_q   <= 32'd0;
            wb_cnt_q     <= 32'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (line_hit) begin
                        hit_cnt_q <= hit_cnt_q + 32'd1;
                        if (p1_write_i) dirty_q[req_idx] <= 1'b1;
                    end else if (p1_req_i) begin
                        miss_cnt_q   <= miss_cnt_q + 32'd1;
                        mem_enable_q <= 1'b1;
                        if (victim_dirty) begin
                            state_q     <= S_WB;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {tag_q[req_idx], req_idx, 5'b0};
                            mem_data_q  <= rd_line;
                        end else begin
                            state_q     <= S_RF;
                            mem_write_q <= 1'b0;
                            mem_addr_q  <= {req_tag, req_idx, 5'b0};
                        end
                    end
                end
                S_WB: begin
                    if (mem_enable_q && mem_ack_i) begin
                        wb_cnt_q     <= wb_cnt_q + 32'd1;
                        state_q      <= S_RF;
                        mem_enable_q <= 1'b0;
                        mem_write_q  <= 1'b0;
                        mem_addr_q   <= 32'd0;
                        mem_data_q   <= '0;
                    end
                end
                S_RF: begin
                    // Coming from a write-back, enable stays low one cycle before the read.
                    if (!mem_enable_q) begin
                        mem_enable_q <= 1'b1;
                        mem_addr_q   <= {req_tag, req_idx, 5'b0};
                    end else if (mem_ack_i) begin
                        valid_q[req_idx] <= 1'b1;
                        dirty_q[req_idx] <= 1'b0;
                        state_q          <= S_FILL;
                        mem_enable_q     <= 1'b0;
                        mem_addr_q       <= 32'd0;
                    end
                end
                S_FILL:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tag and data storage: store-hit word merge and refill install.
    always_ff @(posedge clk_i) begin
        if (idle_hit && p1_write_i) begin
            data_q[req_idx][{req_word, 5'b0} +: 32] <= p1_data_i;
        end
        if (rf_done) begin
            data_q[req_idx] <= mem_data_i;
            tag_q[req_idx]  <= req_tag;
        end
    end

endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Bench for dcache_wb_ctrl: directed scenarios plus random traffic checked
// against a line-level cache and memory model.
module tb_dcache_wb_ctrl;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         p1_req_i, p1_write_i;
    logic [31:0]  p1_addr_i, p1_data_i, p1_data_o;
    logic         p1_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
    logic [31:0]  mem_addr_o, hit_cnt_o, miss_cnt_o, wb_cnt_o;
    logic [255:0] mem_data_o, mem_data_i;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: per-index line records plus a sparse backing memory.
    bit           m_valid [32];
    bit           m_dirty [32];
    logic [21:0]  m_tag   [32];
    logic [255:0] m_line  [32];
    logic [255:0] mem_q   [logic [26:0]];
    int unsigned  e_hit, e_miss, e_wb;
    logic [255:0] last_wb_data;
    logic [255:0] line0;
    logic [31:0]  ra;
    int           guard;

    dcache_wb_ctrl #(.INDEX_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p1_req_i(p1_req_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
        .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .wb_cnt_o(wb_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mem_line(input logic [26:0] la);
        logic [255:0] l;
        if (mem_q.exists(la)) return mem_q[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = {la[23:0], 8'(w)} ^ 32'hA5A5_0000;
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        e_hit = 0; e_miss = 0; e_wb = 0;
    endtask

    task automatic check_counters();
        check("hit_cnt",  256'(hit_cnt_o),  256'(e_hit));
        check("miss_cnt", 256'(miss_cnt_o), 256'(e_miss));
        check("wb_cnt",   256'(wb_cnt_o),   256'(e_wb));
    endtask

    // One CPU access, called at posedge+1; acts as the memory with ack on the lat-th enable cycle.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input int lat);
        logic [4:0]   idx;
        logic [21:0]  tg;
        logic [2:0]   wd;
        bit           exp_hit, exp_wb, acked, stable;
        logic [31:0]  wb_addr, rf_addr, t_addr;
        logic [255:0] wb_line, rf_line, t_data;
        logic         t_wr;
        int           stall_cyc, txns, en_cnt, lim, exp_stall, exp_txns;
        idx = addr[9:5]; tg = addr[31:10]; wd = addr[4:2];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_wb  = !exp_hit && m_valid[idx] && m_dirty[idx];
        wb_addr = {m_tag[idx], idx, 5'b0};
        wb_line = m_line[idx];
        rf_addr = {addr[31:5], 5'b0};
        rf_line = mem_line(addr[31:5]);
        p1_req_i = 1'b1; p1_write_i = wr; p1_addr_i = addr; p1_data_i = wdata;
        stall_cyc = 0; txns = 0; en_cnt = 0; acked = 0; stable = 1; lim = 0;
        t_addr = '0; t_data = '0; t_wr = 1'b0;
        @(negedge clk_i);
        while (p1_stall_o === 1'b1 && lim < 400) begin
            stall_cyc++; lim++;
            if (acked) check("enable_drop", 256'(mem_enable_o), 256'(0));
            acked = 0;
            if (mem_enable_o === 1'b1) begin
                if (en_cnt == 0) begin
                    txns++;
                    t_addr = mem_addr_o; t_wr = mem_write_o; t_data = mem_data_o;
                    if (txns == 1 && exp_wb) begin
                        check("wb_write", 256'(t_wr), 256'(1));
                        check("wb_addr", 256'(t_addr), 256'(wb_addr));
                        check("wb_data", t_data, wb_line);
                        last_wb_data = t_data;
                    end else begin
                        check("rf_write", 256'(t_wr), 256'(0));
                        check("rf_addr", 256'(t_addr), 256'(rf_addr));
                    end
                end else if (mem_addr_o !== t_addr || mem_write_o !== t_wr || mem_data_o !== t_data) begin
                    stable = 0;
                end
                en_cnt++;
                if (en_cnt == lat) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = t_wr ? {8{$urandom()}} : rf_line;
                    if (t_wr && exp_wb) mem_q[wb_addr[31:5]] = wb_line;
                    en_cnt = 0;
                    acked  = 1;
                end
            end
            @(posedge clk_i); #1;
            mem_ack_i  = 1'b0;
            mem_data_i = {8{$urandom()}};
            @(negedge clk_i);
        end
        if (lim >= 400) check("stall_timeout", 256'(p1_stall_o), 256'(0));
        exp_stall = exp_hit ? 0 : (exp_wb ? 2*lat + 3 : lat + 2);
        exp_txns  = exp_hit ? 0 : (exp_wb ? 2 : 1);
        check("stall_cycles", 256'(stall_cyc), 256'(exp_stall));
        check("txn_count", 256'(txns), 256'(exp_txns));
        check("mem_stable", 256'(stable), 256'(1));
        if (!exp_hit) begin
            m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0; m_tag[idx] = tg; m_line[idx] = rf_line;
        end
        check("load_data", 256'(p1_data_o), wr ? 256'(0) : 256'(m_line[idx][wd*32 +: 32]));
        if (wr) begin
            m_line[idx][wd*32 +: 32] = wdata;
            m_dirty[idx] = 1'b1;
        end
        e_hit++;
        if (!exp_hit) e_miss++;
        if (exp_wb) e_wb++;
        @(posedge clk_i); #1;
        p1_req_i = 1'b0; p1_write_i = 1'b0;
        check_counters();
    endtask

    initial begin
        rst_i = 1'b0; p1_req_i = 1'b0; p1_write_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
        mem_ack_i = 1'b0; mem_data_i = '0;
        line0 = mem_line(27'd0);
        line0[31:0] = 32'd5; line0[63:32] = 32'd8;
        mem_q[27'd0] = line0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_stall", 256'(p1_stall_o), 256'(0));
        check("rst_enable", 256'(mem_enable_o), 256'(0));
        check("rst_pdata", 256'(p1_data_o), 256'(0));
        check_counters();
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        access(0, 32'h0000_0000, 32'h0, 10);
        access(0, 32'h0000_0004, 32'h0, 3);
        access(1, 32'h0000_0008, 32'hDEAD_BEEF, 3);
        access(0, 32'h0000_0400, 32'h0, 3);
        check("wb_word2", 256'(last_wb_data[95:64]), 256'(32'hDEAD_BEEF));
        access(0, 32'h0000_0420, 32'h0, 4);
        access(0, 32'h0000_0820, 32'h0, 4);
        access(0, 32'h0000_0C20, 32'h0, 1);
        access(0, 32'h0000_1000, 32'h0, 50);
        access(1, 32'h0000_101C, 32'h1357_9BDF, 2);
        access(0, 32'h0000_0000, 32'h0, 1);

        // Reset during a write-back abandons it and clears every line.
        access(1, 32'h0000_0040, 32'h1234_5678, 2);
        p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h0000_0440;
        guard = 0;
        @(negedge clk_i);
        while (mem_enable_o !== 1'b1 && guard < 20) begin
            guard++;
            @(negedge clk_i);
        end
        check("pre_rst_wb", 256'(mem_write_o), 256'(1));
        rst_i = 1'b0;
        #1;
        check("mid_rst_stall", 256'(p1_stall_o), 256'(0));
        check("mid_rst_enable", 256'(mem_enable_o), 256'(0));
        check("mid_rst_write", 256'(mem_write_o), 256'(0));
        check("mid_rst_addr", 256'(mem_addr_o), 256'(0));
        check("mid_rst_data", mem_data_o, 256'(0));
        check("mid_rst_pdata", 256'(p1_data_o), 256'(0));
        model_reset();
        check_counters();
        @(posedge clk_i); #1;
        p1_req_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        access(0, 32'h0000_0040, 32'h0, 3);

        for (int n = 0; n < 200; n++) begin
            ra = {20'd0, 2'($urandom_range(0, 3)), 3'd0, 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 2'b00};
            access(1'($urandom_range(0, 1)), ra, $urandom(), int'($urandom_range(1, 6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
